decoder_pipe: RTL and testbench

- Parametrised, pipelined binary-to-vector decoder with valid/ready flow control and selectable output coding.
- Next generation of the team's fixed 5-to-32 registered decoder.
- Generalises address width, output width (including non-power-of-two) and latency.
- Adds backpressure, decode modes and out-of-range detection.
- Sits between address-generating control logic and wordline/select drivers in the test datapath.

---
 rtl/decoder_pipe.sv | 104 ++++++++++
 tb/tb_decoder_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_pipe.sv
// decoder_pipe: pipelined binary-to-vector decoder with valid/ready flow.
// Optional err_cnt output enabled by DECODER_PIPE_ERR_CNT_EN.
module decoder_pipe #(
  parameter int A_W   = 5,
  parameter int OUT_W = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   A,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] Z,
  output logic             err
`ifdef DECODER_PIPE_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  logic             stall;
  logic             acc;
  logic             oor;
  logic             de;
  logic [OUT_W-1:0] pat;
  logic [OUT_W-1:0] dz;

  logic [LAT-1:0]   vld;
  logic [LAT-1:0]   es;
  logic [OUT_W-1:0] zs [LAT];

  logic [LAT-1:0]   sv;
  logic [LAT-1:0]   se;
  logic [OUT_W-1:0] sz [LAT];

  assign out_valid = vld[LAT-1];
  assign Z         = zs[LAT-1];
  assign err       = es[LAT-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign acc       = in_valid && in_ready;

  // Decode the incoming address into the stage-1 vector and error flag
  always_comb begin
    oor = int'(A) >= OUT_W;
    de  = oor || (mode == 2'b11);
    pat = '0;
    for (int i = 0; i < OUT_W; i++) begin
      unique case (mode)
        2'b00:   pat[i] = (i == int'(A));
        2'b01:   pat[i] = (i <= int'(A));
        default: pat[i] = (i != int'(A));
      endcase
    end
    dz = '0;
    unique case (1'b1)
      de:  dz = {OUT_W{mode == 2'b10}};
      !de: dz = pat;
    endcase
  end

  // Stage inputs: new decode (or bubble) into stage 1, shift for the rest
  always_comb begin
    sv[0] = acc;
    se[0] = acc && de;
    sz[0] = acc ? dz : '0;
    for (int k = 1; k < LAT; k++) begin
      sv[k] = vld[k-1];
      se[k] = es[k-1];
      sz[k] = zs[k-1];
    end
  end

  // Advance the chain unless stalled; output stage keeps data over bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      es  <= '0;
      for (int k = 0; k < LAT; k++) zs[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < LAT; k++) begin
        vld[k] <= sv[k];
        if (k != LAT-1 || sv[k]) begin
          zs[k] <= sz[k];
          es[k] <= se[k];
        end
      end
    end
  end

`ifdef DECODER_PIPE_ERR_CNT_EN
  // Saturating count of transferred outputs that carried err
  always_ff @(posedge clk) begin
    if (reset)
      err_cnt <= '0;
    else if (out_valid && out_ready && err && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: scoreboard bench for decoder_pipe.
// Reference model computes vectors arithmetically from address and mode.
module tb_decoder_pipe;

  localparam int A_W   = 5;
  localparam int OUT_W = 24;
  localparam int LAT   = 3;

  typedef struct {
    logic [OUT_W-1:0] z;
    logic             e;
    int               cyc;
    bit               lat;
  } exp_t;

  logic             clk = 0;
  logic             reset = 1;
  logic             in_valid = 0;
  logic             in_ready;
  logic [A_W-1:0]   A = '0;
  logic [1:0]       mode = '0;
  logic             out_valid;
  logic             out_ready = 1;
  logic [OUT_W-1:0] Z;
  logic             err;
`ifdef DECODER_PIPE_ERR_CNT_EN
  logic [7:0]       err_cnt;
  int               mcnt = 0;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   latchk = 0;
  exp_t q[$];

  decoder_pipe #(.A_W(A_W), .OUT_W(OUT_W), .LAT(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z(Z),
    .err(err)
`ifdef DECODER_PIPE_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int m);
    exp_t r;
    longint unsigned full = (64'd1 << OUT_W) - 1;
    longint unsigned v;
    r.e = (m == 3) || (a >= OUT_W);
    if (m == 3) v = 0;
    else if (a >= OUT_W) v = (m == 2) ? full : 0;
    else if (m == 0) v = 64'd1 << a;
    else if (m == 1) v = (64'd2 << a) - 1;
    else v = full & ~(64'd1 << a);
    r.z = v[OUT_W-1:0];
    r.cyc = 0;
    r.lat = 0;
    return r;
  endfunction

  task automatic step(input bit iv, input int a, input int m,
                      input bit ordy, output bit acc);
    exp_t e;
    @(posedge clk); #1;
    in_valid  = iv;
    A         = a[A_W-1:0];
    mode      = m[1:0];
    out_ready = ordy;
    @(negedge clk);
    acc = iv && in_ready && !reset;
    if (acc) begin
      e = model(a, m);
      e.cyc = cyc;
      e.lat = latchk;
      q.push_back(e);
    end
  endtask

  task automatic drain(input string nm);
    bit a;
    for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 0, 0, 1, a);
    chk(nm, q.size(), 0);
  endtask

  task automatic send(input int a, input int m);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) step(1, a, m, 1, ok);
    chk("send_accept", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    in_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    q.delete();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Z", Z, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // Monitor: handshake rule, stall stability, in-order scoreboard compare
  initial begin
    bit               hv = 0;
    logic [OUT_W-1:0] hz = '0;
    logic             he = 0;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hv = 0;
`ifdef DECODER_PIPE_ERR_CNT_EN
        mcnt = 0;
`endif
      end else begin
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (hv) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_Z", Z, hz);
          chk("stall_err", err, he);
        end
`ifdef DECODER_PIPE_ERR_CNT_EN
        chk("err_cnt", err_cnt, mcnt);
`endif
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = q.pop_front();
            chk("Z", Z, e.z);
            chk("err", err, e.e);
            if (e.lat) chk("latency", cyc - e.cyc, LAT);
`ifdef DECODER_PIPE_ERR_CNT_EN
            if (e.e && mcnt < 255) mcnt++;
`endif
          end
        end
        hv = out_valid && !out_ready;
        hz = Z;
        he = err;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit a;
    int idx;
    repeat (2) @(posedge clk);
    do_reset();

    // back-to-back sweep, every address including out of range
    latchk = 1;
    for (int i = 0; i < 32; i++) begin
      step(1, i, 0, 1, a);
      chk("sweep_accept", a, 1);
    end
    drain("sweep_drain");

    // modes and range edges
    send(5, 1);
    send(5, 2);
    send(5, 3);
    send(23, 0);
    send(24, 0);
    send(31, 0);
    send(24, 2);
    send(31, 1);
    send(0, 1);
    send(23, 1);
    drain("modes_drain");
    latchk = 0;

    // backpressure: out_ready low for cycles 4..7
    idx = 1;
    for (int c = 0; c < 40 && idx <= 8; c++) begin
      step(1, idx, 0, !(c >= 4 && c <= 7), a);
      if (a) idx++;
    end
    chk("bp_all_sent", idx, 9);
    drain("bp_drain");

    // reset mid-flight: three entries stuck behind a stall are discarded
    for (int i = 0; i < 3; i++) begin
      step(1, 10 + i, 0, 0, a);
      chk("mid_accept", a, 1);
    end
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, a);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, 31),
           $urandom_range(0, 3), $urandom_range(0, 3) != 0, a);
    drain("rand_drain");

`ifdef DECODER_PIPE_ERR_CNT_EN
    for (int i = 0; i < 300; i++) send(31, 0);
    drain("cnt_drain");
    step(0, 0, 0, 1, a);
    chk("err_cnt_sat", err_cnt, 255);
    do_reset();
    chk("err_cnt_rst", err_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
